// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: stall/flush/forward
// controls, memory-freeze handling, a sticky freeze watchdog and saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             RegWriteE,
  input  logic             ResultSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic             MemAccessM,
  input  logic             mem_ready,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             clr_counters,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  logic             freeze;
  logic             lw_stall;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wr_m,
                                         input logic [4:0] rd_m, input logic wr_w,
                                         input logic [4:0] rd_w);
    if (wr_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  assign freeze   = MemAccessM & ~mem_ready;
  assign lw_stall = ResultSrcE & RegWriteE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

  // Priority: freeze > taken branch > load-use > run; everything held low in reset.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst) begin
      ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
      ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
      if (freeze) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_comb begin
    wait_cnt_d = 16'd0;
    if (freeze)
      wait_cnt_d = (wait_cnt_q >= TIMEOUT_C) ? TIMEOUT_C : wait_cnt_q + 16'd1;
    timeout_d = timeout_q | (freeze & (wait_cnt_d == TIMEOUT_C));

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_counters) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (StallF && stall_cnt_q != '1)                 stall_cnt_d = stall_cnt_q + 1'b1;
      if (PCSrcE && !freeze && flush_cnt_q != '1)      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q  <= 16'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
  assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed plan scenarios plus random cycles, all
// checked against a rule-level reference model of controls, counters and watchdog.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteE, ResultSrcE, RegWriteM, MemAccessM, mem_ready, RegWriteW, PCSrcE, clr_counters;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic mem_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_stall   = 0;
  int m_flush   = 0;
  int m_run     = 0;
  bit m_timeout = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemAccessM(MemAccessM), .mem_ready(mem_ready),
    .RdW(RdW), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .clr_counters(clr_counters),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_freeze();
    return MemAccessM && !mem_ready;
  endfunction

  function automatic bit m_lw();
    return ResultSrcE && RegWriteE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
  endfunction

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  function automatic logic [6:0] m_ctrl();
    if (!rst)          return 7'b0000000;
    if (m_freeze())    return 7'b1111001;
    if (PCSrcE)        return 7'b0000110;
    if (m_lw())        return 7'b1100010;
    return 7'b0000000;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (!rst) return 2'b00;
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_now();
    chk("ctrl", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, m_ctrl());
    chk("fwdA", ForwardAE, m_fwd(Rs1E));
    chk("fwdB", ForwardBE, m_fwd(Rs2E));
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_count", flush_count, m_flush);
    chk("mem_timeout", mem_timeout, m_timeout);
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic step();
    bit stall_now, flush_now, frz;
    #1;
    check_now();
    stall_now = m_ctrl()[6];
    frz       = m_freeze();
    flush_now = PCSrcE && !frz;
    @(posedge clk);
    if (clr_counters) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (stall_now && m_stall < CNT_MAX) m_stall++;
      if (flush_now && m_flush < CNT_MAX) m_flush++;
    end
    m_run = frz ? m_run + 1 : 0;
    if (m_run >= TIMEOUT) m_timeout = 1;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteE, ResultSrcE, RegWriteM, MemAccessM, RegWriteW, PCSrcE, clr_counters} = '0;
    mem_ready = 1'b1;
  endtask

  task automatic set_loaduse();
    ResultSrcE = 1; RegWriteE = 1; RdE = 5'd5; Rs1D = 5'd5; Rs2D = 5'd7;
  endtask

  int frz_left = 0;

  initial begin
    idle_inputs();
    RegWriteM = 1; RdM = 5'd3; Rs1E = 5'd3; MemAccessM = 1; mem_ready = 0; PCSrcE = 1;
    #3;
    check_now();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();

    // load-use: one bubble, stall counter 0 -> 1
    set_loaduse();
    step();
    chk("t1_stall_cnt", stall_cycles, 1);
    idle_inputs();
    step();
    chk("t1_one_bubble", {StallF, StallD, FlushE}, 3'b000);

    // forwarding priority and x0
    RegWriteM = 1; RdM = 5'd3; RegWriteW = 1; RdW = 5'd3; Rs1E = 5'd3; Rs2E = 5'd3;
    step();
    RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    step();
    RdM = 5'd0; RdW = 5'd9; Rs1E = 5'd9; Rs2E = 5'd4;
    step();
    idle_inputs();

    // branch beats load-use
    set_loaduse(); PCSrcE = 1;
    step();
    chk("t3_flush_cnt", flush_count, 1);
    idle_inputs();

    // freeze with pending branch, then branch acts after freeze drops
    clr_counters = 1;
    step();
    clr_counters = 0;
    PCSrcE = 1; MemAccessM = 1; mem_ready = 0;
    repeat (3) step();
    mem_ready = 1;
    step();
    chk("t4_stall_cnt", stall_cycles, 3);
    chk("t4_flush_cnt", flush_count, 1);
    idle_inputs();

    // watchdog: rises on 4th freeze edge, sticky through clr_counters
    MemAccessM = 1; mem_ready = 0;
    repeat (3) step();
    chk("t5_not_yet", mem_timeout, 0);
    step();
    chk("t5_set", mem_timeout, 1);
    repeat (2) step();
    idle_inputs();
    clr_counters = 1;
    step();
    clr_counters = 0;
    step();
    chk("t5_sticky", mem_timeout, 1);

    // saturation, clear, async reset mid-stall
    set_loaduse();
    repeat (20) step();
    chk("t6_sat", stall_cycles, 15);
    clr_counters = 1;
    step();
    clr_counters = 0;
    chk("t6_clr", stall_cycles, 0);
    step();
    RegWriteM = 1; RdM = 5'd2; Rs1E = 5'd2;
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_ctrl", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, 7'b0);
    chk("t6_rst_fwd", ForwardAE, 2'b00);
    chk("t6_rst_cnt", stall_cycles, 0);
    chk("t6_rst_to", mem_timeout, 0);
    m_stall = 0; m_flush = 0; m_run = 0; m_timeout = 0;
    @(negedge clk);

    // reset released mid-freeze: wait count restarts
    idle_inputs();
    MemAccessM = 1; mem_ready = 0;
    rst = 1'b1;
    repeat (TIMEOUT - 1) step();
    chk("rst_restart", mem_timeout, 0);
    idle_inputs();
    step();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteE  = 1'($urandom); ResultSrcE = 1'($urandom);
      RegWriteM  = 1'($urandom); RegWriteW  = 1'($urandom);
      PCSrcE       = ($urandom_range(0, 3) == 0);
      clr_counters = ($urandom_range(0, 39) == 0);
      if (frz_left == 0 && $urandom_range(0, 7) == 0) frz_left = $urandom_range(1, 7);
      if (frz_left > 0) begin
        MemAccessM = 1; mem_ready = 0; frz_left--;
      end else begin
        MemAccessM = 1'($urandom); mem_ready = 1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
